// File: rtl/seg_scan.sv
// seg_scan: six-digit (hh mm ss) multiplexed 7-segment driver.
// Takes packed-BCD seconds/minutes/hours bytes, snapshots them once per
// frame (LOAD), then drives each digit for SCAN_DIV clocks (DRIVE) with an
// optional all-off gap of GAP_CYCLES clocks between digits (GAP).
// seg is {dp,g,f,e,d,c,b,a}, active low; an is active low with an[0] being
// the seconds ones digit and an[5] the hours tens digit.
// Nibble 4'hB is blank, which is how upstream counters make a field blink.
// Optional build macro HOUR_LZ_BLANK_EN: blank a leading zero in hours tens.
// dbg_state_o exposes the FSM state (0=LOAD, 1=DRIVE, 2=GAP).
module seg_scan #(
  parameter int SCAN_DIV   = 50000,
  parameter int GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cnt_s,
  input  logic [7:0] cnt_m,
  input  logic [7:0] cnt_h,
  output logic [7:0] seg,
  output logic [5:0] an,
  output logic [1:0] dbg_state_o
);

  // Prescaler is shared by DRIVE and GAP, so it must hold the larger count.
  localparam int MAXV = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
  localparam int PW   = (MAXV > 1) ? $clog2(MAXV) : 1;
  localparam logic [PW-1:0] TC_DRIVE = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] TC_GAP   = PW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t          state_q;
  logic [2:0]      idx_q;
  logic [PW-1:0]   pre_q;
  logic [23:0]     snap_q;
  logic [7:0]      seg_q;
  logic [5:0]      an_q;
  logic [2:0]      idx_inc;
  logic [3:0]      nib_inc;

  // Pick the BCD nibble for a digit index out of the {h,m,s} snapshot.
  function automatic logic [3:0] nib_sel(input logic [23:0] snap, input logic [2:0] idx);
    logic [3:0] n;
    case (idx)
      3'd0:    n = snap[3:0];
      3'd1:    n = snap[7:4];
      3'd2:    n = snap[11:8];
      3'd3:    n = snap[15:12];
      3'd4:    n = snap[19:16];
      default: n = snap[23:20];
    endcase
    return n;
  endfunction

  // Nibble to active-low segments; dp lights on idx 2 and 4 unless blank.
  function automatic logic [7:0] decode(input logic [3:0] nib, input logic [2:0] idx);
    logic [6:0] segs;
    logic       blank;
    logic       dp_n;
    blank = (nib == 4'hB);
`ifdef HOUR_LZ_BLANK_EN
    if (idx == 3'd5 && nib == 4'h0) blank = 1'b1;
`endif
    case (nib)
      4'h0:    segs = 7'h40;
      4'h1:    segs = 7'h79;
      4'h2:    segs = 7'h24;
      4'h3:    segs = 7'h30;
      4'h4:    segs = 7'h19;
      4'h5:    segs = 7'h12;
      4'h6:    segs = 7'h02;
      4'h7:    segs = 7'h78;
      4'h8:    segs = 7'h00;
      4'h9:    segs = 7'h10;
      default: segs = 7'h3F;  // "-" for A, C..F (B handled as blank)
    endcase
    dp_n = !(idx == 3'd2 || idx == 3'd4);
    return blank ? 8'hFF : {dp_n, segs};
  endfunction

  // Next digit index and its nibble, used when advancing to the next digit.
  assign idx_inc = idx_q + 3'd1;
  assign nib_inc = nib_sel(snap_q, idx_inc);

  // Scan FSM; outputs are registered and change on the edge entering a state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      idx_q   <= 3'd0;
      pre_q   <= '0;
      snap_q  <= 24'h0;
      seg_q   <= 8'hFF;
      an_q    <= 6'h3F;
    end else begin
      case (state_q)
        S_LOAD: begin
          snap_q  <= {cnt_h, cnt_m, cnt_s};
          idx_q   <= 3'd0;
          pre_q   <= '0;
          state_q <= S_DRIVE;
          an_q    <= 6'h3E;
          seg_q   <= decode(cnt_s[3:0], 3'd0);
        end
        S_DRIVE: begin
          if (pre_q == TC_DRIVE) begin
            pre_q <= '0;
            if (GAP_CYCLES > 0) begin
              state_q <= S_GAP;
              an_q    <= 6'h3F;
              seg_q   <= 8'hFF;
            end else if (idx_q == 3'd5) begin
              state_q <= S_LOAD;
              an_q    <= 6'h3F;
              seg_q   <= 8'hFF;
            end else begin
              idx_q <= idx_inc;
              an_q  <= ~(6'd1 << idx_inc);
              seg_q <= decode(nib_inc, idx_inc);
            end
          end else begin
            pre_q <= pre_q + 1'b1;
          end
        end
        S_GAP: begin
          if (pre_q == TC_GAP) begin
            pre_q <= '0;
            if (idx_q == 3'd5) begin
              state_q <= S_LOAD;
              an_q    <= 6'h3F;
              seg_q   <= 8'hFF;
            end else begin
              state_q <= S_DRIVE;
              idx_q   <= idx_inc;
              an_q    <= ~(6'd1 << idx_inc);
              seg_q   <= decode(nib_inc, idx_inc);
            end
          end else begin
            pre_q <= pre_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_LOAD;
          pre_q   <= '0;
          an_q    <= 6'h3F;
          seg_q   <= 8'hFF;
        end
      endcase
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: dut_a (SCAN_DIV=4, GAP_CYCLES=1, 31-clock frame) is
// checked frame by frame against a vector table; dut_b (SCAN_DIV=1,
// GAP_CYCLES=0, 7-clock frame) checks the gapless sequence.
module tb_seg_scan;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] cnt_s, cnt_m, cnt_h;
  logic [7:0] seg_a, seg_b;
  logic [5:0] an_a, an_b;
  logic [1:0] st_a, st_b;
  logic [7:0] b_s = 8'h56, b_m = 8'h34, b_h = 8'h12;

  seg_scan #(.SCAN_DIV(4), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .cnt_s(cnt_s), .cnt_m(cnt_m), .cnt_h(cnt_h),
    .seg(seg_a), .an(an_a), .dbg_state_o(st_a)
  );

  seg_scan #(.SCAN_DIV(1), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .cnt_s(b_s), .cnt_m(b_m), .cnt_h(b_h),
    .seg(seg_b), .an(an_b), .dbg_state_o(st_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [13:0] exp_q[$];

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  // exp_seg holds the expected seg byte per digit, idx0 in bits [7:0].
  typedef struct {
    logic [7:0]  h, m, s;
    int          chg_cyc;   // cycle in frame at which cnt_m is changed (0 = never)
    logic [7:0]  chg_m;
    logic [47:0] exp_seg;
  } vec_t;

  vec_t vecs[8];

  // Driver: call at the negedge of a LOAD cycle with inputs set; checks
  // one full frame and returns at the negedge of the following LOAD cycle.
  task automatic run_frame(input int vi, input vec_t v);
    logic [13:0] e;
    logic [47:0] es;
    es = v.exp_seg;
    for (int d = 0; d < 6; d++) begin
      for (int k = 0; k < 4; k++) exp_q.push_back({~(6'd1 << d), es[d*8 +: 8]});
      exp_q.push_back({6'h3F, 8'hFF});
    end
    exp_q.push_back({6'h3F, 8'hFF});  // next LOAD at clock 31
    for (int c = 1; c <= 31; c++) begin
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("frame%0d_c%0d", vi, c), {an_a, seg_a}, e);
      if (c == v.chg_cyc) cnt_m = v.chg_m;
    end
    chk($sformatf("frame%0d_load_state", vi), {12'h0, st_a}, 14'h0);
  endtask

  initial begin
    // idx0..idx5 = s ones, s tens, m ones, m tens, h ones, h tens
    vecs[0] = '{8'h12, 8'h34, 8'h56, 0, 8'h00, {8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'h82}};
    // tearing: cnt_m -> 35 during idx1 (cycles 6..9); this frame keeps "4"
    vecs[1] = '{8'h12, 8'h34, 8'h56, 7, 8'h35, {8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'h82}};
    vecs[2] = '{8'h12, 8'h35, 8'h56, 0, 8'h00, {8'hF9, 8'h24, 8'hB0, 8'h12, 8'h92, 8'h82}};
    // blink: seconds blanked, an still walks
    vecs[3] = '{8'h12, 8'h34, 8'hBB, 0, 8'h00, {8'hF9, 8'h24, 8'hB0, 8'h19, 8'hFF, 8'hFF}};
    // invalid nibble in hours tens, 7 with dp in hours ones
    vecs[4] = '{8'hE7, 8'h34, 8'h56, 0, 8'h00, {8'hBF, 8'h78, 8'hB0, 8'h19, 8'h92, 8'h82}};
    // blank on the dp digits suppresses dp; A and F show "-"
    vecs[5] = '{8'hAB, 8'hFB, 8'h78, 0, 8'h00, {8'hBF, 8'hFF, 8'hBF, 8'hFF, 8'hF8, 8'h80}};
`ifdef HOUR_LZ_BLANK_EN
    vecs[6] = '{8'h09, 8'h00, 8'h00, 0, 8'h00, {8'hFF, 8'h10, 8'hC0, 8'h40, 8'hC0, 8'hC0}};
`else
    vecs[6] = '{8'h09, 8'h00, 8'h00, 0, 8'h00, {8'hC0, 8'h10, 8'hC0, 8'h40, 8'hC0, 8'hC0}};
`endif
    vecs[7] = '{8'h23, 8'h59, 8'h01, 0, 8'h00, {8'hA4, 8'h30, 8'h92, 8'h10, 8'hC0, 8'hF9}};

    // ---- reset state ----
    cnt_h = vecs[0].h; cnt_m = vecs[0].m; cnt_s = vecs[0].s;
    @(negedge clk);
    @(negedge clk);
    chk("reset_a_out", {an_a, seg_a}, {6'h3F, 8'hFF});
    chk("reset_a_state", {12'h0, st_a}, 14'h0);
    chk("reset_b_out", {an_b, seg_b}, {6'h3F, 8'hFF});
    rst = 1'b0;
    chk("release_load_blank", {an_a, seg_a}, {6'h3F, 8'hFF});

    // ---- table-driven frames ----
    for (int i = 0; i < 8; i++) begin
      cnt_h = vecs[i].h; cnt_m = vecs[i].m; cnt_s = vecs[i].s;
      run_frame(i, vecs[i]);
    end

    // ---- async reset mid-DRIVE ----
    @(posedge clk);           // enters DRIVE idx0
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", {an_a, seg_a}, {6'h3F, 8'hFF});
    chk("async_rst_state", {12'h0, st_a}, 14'h0);
    @(negedge clk);
    rst = 1'b0;
    run_frame(8, vecs[7]);    // frame restarts from LOAD

    // ---- gapless build: 7-clock frame ----
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("b_load_blank", {an_b, seg_b}, {6'h3F, 8'hFF});
    for (int k = 0; k < 6; k++) begin
      logic [47:0] es;
      es = vecs[0].exp_seg;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b_digit%0d", k), {an_b, seg_b}, {~(6'd1 << k), es[k*8 +: 8]});
    end
    @(posedge clk);
    @(negedge clk);
    chk("b_next_load", {an_b, seg_b}, {6'h3F, 8'hFF});
    chk("b_next_load_state", {12'h0, st_b}, 14'h0);
    @(posedge clk);
    @(negedge clk);
    chk("b_wrap_digit0", {an_b, seg_b}, {6'h3E, 8'h82});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
